ser_piso_feeder: RTL and testbench
==================================

Name: ser_piso_feeder

Overview:
- Parallel-in/serial-out stage directly upstream of the overlapping 10101 Moore detector.
- Accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per enabled clock on ser_out, which drives the detector's serial input.
- ser_valid qualifies each bit.
- Supports back-to-back words with no idle bubble.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din_valid  input  1  upstream word valid.
- din  input  WIDTH  word to serialise; sampled only on accept.
- din_ready  output  1  stage can accept a word this cycle.
- bit_en  input  1  bit-rate strobe; the shifter advances only on cycles where it is 1.
- ser_out  output  1  current serial bit, registered.
- ser_valid  output  1  ser_out holds a new bit this cycle, registered.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse, coincident with the last bit of a frame.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; shift register and bit counter clear to 0.
  - ser_out=0, ser_valid=0, busy=0, frame_done=0, din_ready=1 (combinational from state).
  - Reset asserted mid-frame aborts the frame; the remaining bits are never emitted.
- Accept: a word is accepted on a rising edge where din_valid && din_ready.
- din_ready (combinational) = (state==IDLE) || (state==SHIFT && bit_en && last bit being emitted this cycle).
- States:
  - IDLE:
    - busy=0; ser_valid=0; ser_out holds its last value.
    - On accept: load din and set cnt=0. Next cycle state=SHIFT, with the first bit presented on ser_out and ser_valid=bit_en.
  - SHIFT:
    - Each cycle with bit_en=1: present the bit at index cnt (order per MSB_FIRST) on ser_out, set ser_valid=1, then cnt++.
    - When the bit with cnt==FRAME_LEN-1 is emitted, frame_done=1 in the same cycle.
    - After the last bit: if an accept happens on that edge, reload and continue in SHIFT (no gap); otherwise go to IDLE.
  - Cycles with bit_en=0 in SHIFT: ser_valid=0, ser_out holds, cnt holds, frame_done=0, din_ready=0.
- Latency:
  - First bit appears in the cycle after the accept edge, given bit_en=1.
  - A full frame takes FRAME_LEN enabled cycles.
- FRAME_LEN = WIDTH (WIDTH+1 with the optional feature).
- Counter width = clog2(FRAME_LEN+1); no wrap occurs, because cnt reloads to 0 on each new frame.
- din changes while not accepting have no effect.
- din_valid held high during a frame is not accepted until the last-bit cycle.
- busy=1 from the cycle after accept until the cycle after the last bit, unless a back-to-back load keeps it high.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the latched word) is emitted.
  - FRAME_LEN = WIDTH+1.
  - frame_done and the din_ready last-bit term apply to the parity bit.
- Undefined: no parity bit; FRAME_LEN = WIDTH; no parity logic is synthesised.

Test Plan:
- Basic MSB-first. WIDTH=8, MSB_FIRST=1, bit_en=1, din=8'hA8 accepted at cycle 0 -> ser_out over cycles 1..8 = 1,0,1,0,1,0,0,0; ser_valid=1 for cycles 1..8; frame_done only at cycle 8; busy=0 and din_ready=1 at cycle 9.
- LSB-first. MSB_FIRST=0, din=8'h15 -> bits 1,0,1,0,1,0,0,0; a detector fed from this output asserts its match in the cycle after the 5th bit.
- Back-to-back. din_valid held high, with 8'hA8 then 8'hFF -> 16 consecutive ser_valid=1 cycles with no gap; din_ready=1 only at cycles 0 and 8; frame_done at cycles 8 and 16.
- Stall. bit_en pattern 1,0,0,1,... during a frame with din=8'hA8 -> ser_valid=0 and ser_out held during stalled cycles; bit order is unchanged; frame_done occurs on the 8th enabled cycle.
- Reset mid-frame. Assert rst after bit 3 of 8'hA8 -> ser_valid=0, busy=0, ser_out=0 immediately (asynchronous); after release, din_ready=1 and a new word 8'h01 serialises correctly.
- Parity, with SER_PARITY_EN defined. din=8'h07 -> 8 data bits then parity bit 1; frame_done on the 9th bit; din=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/ser_piso_feeder.sv
// Parallel-in/serial-out feeder for the serial 10101 detector: valid/ready word in, one bit per bit_en out.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every frame.
module ser_piso_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LM1  = CW'(FRAME_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    // cnt counts bits already placed on ser_out for the current word
    logic [CW-1:0]    cnt;
    logic             last_shown;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // The last bit is on ser_out while cnt sits at FRAME_LEN; an enabled cycle there may reload.
    assign last_shown = (state == S_SHIFT) && (cnt == CNT_LAST);
    assign din_ready  = (state == S_IDLE) || (last_shown && bit_en);
    assign accept     = din_valid && din_ready;
    assign busy       = (state == S_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                state <= S_SHIFT;
`ifdef SER_PARITY_EN
                par   <= ^din;
`endif
                // An enabled accept edge already presents the first bit, so frames chain without a bubble.
                if (bit_en) begin
                    ser_out   <= head(din);
                    shreg     <= advance(din);
                    cnt       <= CW'(1);
                    ser_valid <= 1'b1;
                end else begin
                    shreg <= din;
                    cnt   <= '0;
                end
            end else if (state == S_SHIFT) begin
                if (last_shown) begin
                    state <= S_IDLE;
                end else if (bit_en) begin
                    ser_valid  <= 1'b1;
                    frame_done <= (cnt == CNT_LM1);
                    cnt        <= cnt + 1'b1;
`ifdef SER_PARITY_EN
                    if (cnt == CW'(WIDTH)) begin
                        ser_out <= par;
                    end else begin
                        ser_out <= head(shreg);
                        shreg   <= advance(shreg);
                    end
`else
                    ser_out <= head(shreg);
                    shreg   <= advance(shreg);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ser_piso_feeder.sv
// Bench for ser_piso_feeder: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a frame-level reference (word, bits emitted so far, active flag).
module tb_ser_piso_feeder;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din_valid = 1'b0;
    logic         bit_en = 1'b0;
    logic [W-1:0] din = '0;

    logic rdy_m, so_m, sv_m, busy_m, fd_m;
    logic rdy_l, so_l, sv_l, busy_l, fd_l;

    int total = 0;
    int bad   = 0;

    bit           m_active;
    logic [W-1:0] m_word;
    int           m_n;
    bit           m_so_m, m_so_l, m_sv, m_fd;
    logic [W-1:0] cap;

    ser_piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(rdy_m),
        .bit_en(bit_en), .ser_out(so_m), .ser_valid(sv_m), .busy(busy_m), .frame_done(fd_m)
    );

    ser_piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(rdy_l),
        .bit_en(bit_en), .ser_out(so_l), .ser_valid(sv_l), .busy(busy_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    // Bit k of a frame: data bits in the chosen order, then even parity of the word.
    function automatic bit ref_bit(input logic [W-1:0] w, input int k, input bit msb);
        if (k >= W) return ^w;
        return msb ? w[W-1-k] : w[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_n = 0; m_so_m = 1'b0; m_so_l = 1'b0; m_sv = 1'b0; m_fd = 1'b0;
    endtask

    task automatic model_emit();
        m_so_m = ref_bit(m_word, m_n, 1'b1);
        m_so_l = ref_bit(m_word, m_n, 1'b0);
        m_sv   = 1'b1;
        m_fd   = (m_n == FL - 1);
        m_n++;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".so_m"},   {31'd0, so_m},   {31'd0, m_so_m});
        chk({tag, ".sv_m"},   {31'd0, sv_m},   {31'd0, m_sv});
        chk({tag, ".busy_m"}, {31'd0, busy_m}, {31'd0, m_active});
        chk({tag, ".fd_m"},   {31'd0, fd_m},   {31'd0, m_fd});
        chk({tag, ".so_l"},   {31'd0, so_l},   {31'd0, m_so_l});
        chk({tag, ".sv_l"},   {31'd0, sv_l},   {31'd0, m_sv});
        chk({tag, ".busy_l"}, {31'd0, busy_l}, {31'd0, m_active});
        chk({tag, ".fd_l"},   {31'd0, fd_l},   {31'd0, m_fd});
    endtask

    // One clock: drive inputs, check ready, take the edge, advance the reference, check outputs.
    task automatic cycle(input string tag, input bit v, input logic [W-1:0] d, input bit en);
        bit er;
        din_valid = v; din = d; bit_en = en;
        #1;
        er = !m_active || (m_n == FL && en);
        chk({tag, ".rdy_m"}, {31'd0, rdy_m}, {31'd0, er});
        chk({tag, ".rdy_l"}, {31'd0, rdy_l}, {31'd0, er});
        @(posedge clk);
        m_sv = 1'b0; m_fd = 1'b0;
        if (v && er) begin
            m_word = d; m_active = 1'b1; m_n = 0;
            if (en) model_emit();
        end else if (m_active) begin
            if (m_n == FL) m_active = 1'b0;
            else if (en) model_emit();
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        m_word = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.rdy_m", {31'd0, rdy_m}, 32'd1);
        rst = 1'b0;

        // Basic frame, 8'hA8: collect the MSB-first stream and compare to the word
        cap = '0;
        cycle("basic", 1'b1, 8'hA8, 1'b1);
        cap = {cap[W-2:0], so_m};
        for (int i = 1; i < W; i++) begin
            cycle("basic", 1'b0, 8'h00, 1'b1);
            cap = {cap[W-2:0], so_m};
        end
        chk("basic.word", {24'd0, cap}, 32'h0000_00A8);
        chk("basic.done8", {31'd0, fd_m}, 32'd1);
        for (int i = 0; i < FL - W + 1; i++) cycle("basic.tail", 1'b0, 8'h00, 1'b1);
        chk("basic.idle_busy", {31'd0, busy_m}, 32'd0);

        // LSB-first pattern 8'h15 -> 1,0,1,0,1,0,0,0 on the LSB instance
        for (int i = 0; i < FL + 2; i++) cycle("lsb", i == 0, 8'h15, 1'b1);

        // Back-to-back A8 then FF with valid held through the first last-bit cycle
        for (int i = 0; i <= FL; i++) cycle("b2b", 1'b1, (i == 0) ? 8'hA8 : 8'hFF, 1'b1);
        chk("b2b.nogap", {31'd0, sv_m}, 32'd1);
        for (int i = 0; i < FL + 2; i++) cycle("b2b.tail", 1'b0, 8'h00, 1'b1);

        // Stall pattern 1,0,0,1,... while din wiggles off-accept
        for (int i = 0; i < 3 * FL + 4; i++)
            cycle("stall", i == 0, 8'hA8 ^ W'(i), (i % 4 == 0) || (i % 4 == 3));
        for (int i = 0; i < 3; i++) cycle("stall.tail", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset after the 3rd bit of 8'hA8
        cycle("mrst", 1'b1, 8'hA8, 1'b1);
        cycle("mrst", 1'b0, 8'h00, 1'b1);
        cycle("mrst", 1'b0, 8'h00, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs("mrst.async");
        chk("mrst.rdy", {31'd0, rdy_m}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < FL + 2; i++) cycle("mrst.new", i == 0, 8'h01, 1'b1);

`ifdef SER_PARITY_EN
        for (int i = 0; i < FL; i++) cycle("par07", i == 0, 8'h07, 1'b1);
        chk("par07.bit", {31'd0, so_m}, 32'd1);
        chk("par07.done", {31'd0, fd_m}, 32'd1);
        cycle("par07.tail", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < FL; i++) cycle("par03", i == 0, 8'h03, 1'b1);
        chk("par03.bit", {31'd0, so_m}, 32'd0);
        cycle("par03.tail", 1'b0, 8'h00, 1'b1);
`endif

        // Randomized valid/data/strobe traffic
        for (int i = 0; i < 600; i++)
            cycle("rand", $urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
